// File: rtl/sum_window_accumulator.sv
// sum_window_accumulator: sums WIN_LEN accepted samples per window and
// presents the window total and average on a registered valid/ready port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   clear                     discard the partial window
//   in_valid/in_ready/in_data upstream sample handshake
//   out_valid/out_ready       result handshake
//   out_sum, out_avg          window total and total >> LOG_WIN
module sum_window_accumulator #(
    parameter int DATA_W  = 8,
    parameter int WIN_LEN = 4,
    parameter int LOG_WIN = 2,
    parameter int ACC_W   = DATA_W + LOG_WIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_avg
);

    typedef enum logic {
        ACC   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [LOG_WIN-1:0] cnt, cnt_n;
    logic [ACC_W-1:0]   pend, pend_n;
    logic [ACC_W-1:0]   sum_n;
    logic               vld_n;

    logic               in_acc;
    logic               out_acc;
    logic               last;
    logic [ACC_W-1:0]   total;

    // in_ready comes straight from the state flop, so it never
    // depends combinationally on out_ready.
    assign in_ready = (state == ACC);
    assign out_avg  = out_sum[ACC_W-1:LOG_WIN];

    // A sample presented together with clear is dropped.
    assign in_acc  = in_valid & in_ready & ~clear;
    assign out_acc = out_valid & out_ready;
    assign last    = (cnt == LOG_WIN'(WIN_LEN - 1));
    assign total   = acc + ACC_W'(in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            pend      <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            pend      <= pend_n;
            out_sum   <= sum_n;
            out_valid <= vld_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        pend_n  = pend;
        sum_n   = out_sum;
        vld_n   = out_valid;

        // A taken result drops valid unless a new one loads below.
        if (out_acc) begin
            vld_n = 1'b0;
        end

        if (clear) begin
            acc_n = '0;
            cnt_n = '0;
        end

        unique case (state)
            ACC: begin
                if (in_acc) begin
                    if (last) begin
                        acc_n = '0;
                        cnt_n = '0;
                        if (!out_valid || out_acc) begin
                            sum_n = total;
                            vld_n = 1'b1;
                        end else begin
                            pend_n  = total;
                            state_n = STALL;
                        end
                    end else begin
                        acc_n = total;
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            STALL: begin
                if (out_acc) begin
                    sum_n   = pend;
                    vld_n   = 1'b1;
                    state_n = ACC;
                end
            end
            default: begin
                state_n = ACC;
            end
        endcase
    end

endmodule
